fetch_ctrl: RTL

//  Instruction-fetch controller; sits directly upstream of the 32-bit PC register.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_timeout_cnt.sv | 29 ++
 rtl/fetch_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch controller: state encoding and datapath widths.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] INST_STEP = 32'd4;

  typedef enum logic [2:0] {
    StBoot,
    StFetch,
    StHold,
    StKill,
    StErr
  } fetch_state_e;

endpackage

// File: rtl/fetch_timeout_cnt.sv
// Wait-cycle counter for an outstanding fetch; flags expiry on the last allowed wait cycle.
module fetch_timeout_cnt #(
  parameter int unsigned MAX_COUNT = 255
) (
  input  logic Clk,
  input  logic Clrn,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int unsigned W = $clog2(MAX_COUNT + 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A fresh request (clear) always restarts the budget, even on the final cycle.
  assign expired = inc && !clear && (cnt_q == W'(MAX_COUNT - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: drives the PC register, imem req/ack and the decode handshake.
// Optional fetch timeout with sticky fault is built when FETCH_TIMEOUT_EN is defined.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned     TIMEOUT_CYCLES = 255
) (
  input  logic            Clk,
  input  logic            Clrn,
  output logic [XLEN-1:0] pc_d,
  output logic            pc_en,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            fault
);

  fetch_state_e    state_q, state_d, fsm_next;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] redir_q, redir_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            valid_q, valid_d;
  logic            pc_en_raw;
  logic            timeout_hit;

  always_comb begin
    fsm_next  = state_q;
    addr_d    = addr_q;
    redir_d   = redir_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
    pc_d      = addr_q;
    pc_en_raw = 1'b0;
    unique case (state_q)
      StBoot: begin
        pc_d      = RESET_PC;
        pc_en_raw = 1'b1;
        addr_d    = RESET_PC;
        fsm_next  = StFetch;
      end
      StFetch: begin
        if (redirect) begin
          pc_d      = redirect_target;
          pc_en_raw = 1'b1;
          if (imem_ack) begin
            addr_d = redirect_target;
          end else begin
            redir_d  = redirect_target;
            fsm_next = StKill;
          end
        end else if (imem_ack) begin
          inst_d    = imem_rdata;
          inst_pc_d = addr_q;
          valid_d   = 1'b1;
          pc_d      = addr_q + INST_STEP;
          pc_en_raw = 1'b1;
          fsm_next  = StHold;
        end
      end
      StKill: begin
        // Wrong-path request stays on the bus until memory answers; its data is discarded.
        if (redirect) begin
          redir_d   = redirect_target;
          pc_d      = redirect_target;
          pc_en_raw = 1'b1;
        end
        if (imem_ack) begin
          addr_d   = redirect ? redirect_target : redir_q;
          fsm_next = StFetch;
        end
      end
      StHold: begin
        if (redirect) begin
          valid_d   = 1'b0;
          addr_d    = redirect_target;
          pc_d      = redirect_target;
          pc_en_raw = 1'b1;
          fsm_next  = StFetch;
        end else if (inst_ready) begin
          valid_d  = 1'b0;
          addr_d   = inst_pc_q + INST_STEP;
          fsm_next = StFetch;
        end
      end
      StErr: fsm_next = StErr;
      default: fsm_next = StBoot;
    endcase
  end

`ifdef FETCH_TIMEOUT_EN
  logic cnt_clear, cnt_inc, fault_q;

  assign cnt_inc   = ((state_q == StFetch) || (state_q == StKill)) && !imem_ack;
  assign cnt_clear = ((fsm_next == StFetch) || (fsm_next == StKill)) &&
                     ((fsm_next != state_q) || imem_ack);

  fetch_timeout_cnt #(
    .MAX_COUNT(TIMEOUT_CYCLES)
  ) u_timeout (
    .Clk    (Clk),
    .Clrn   (Clrn),
    .clear  (cnt_clear),
    .inc    (cnt_inc),
    .expired(timeout_hit)
  );

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      fault_q <= 1'b0;
    end else if (timeout_hit) begin
      fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;
`else
  assign timeout_hit = 1'b0;
  assign fault       = 1'b0;
`endif

  assign state_d = timeout_hit ? StErr : fsm_next;
  assign pc_en   = pc_en_raw && !timeout_hit;

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q   <= StBoot;
      addr_q    <= '0;
      redir_q   <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      redir_q   <= redir_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
    end
  end

  assign imem_req   = (state_q == StFetch) || (state_q == StKill);
  assign imem_addr  = addr_q;
  assign inst_valid = valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

endmodule
